// File: rtl/fifo_write_arbiter.sv
// Write-side front end of the element-chain FIFO: round-robin sharing of the
// single FIFO input between two producers, plus flush sequencing.
module fifo_write_arbiter #(
    parameter int WIDTH        = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             ack1,
    input  logic             flush,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic [WIDTH-1:0] fifo_d_in,
    output logic             fifo_d_in_strobe,
    output logic             fifo_reset,
    output logic             flush_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t           state_r, state_nx;
    logic             last_r, last_nx;
    logic             pend_r, pend_nx;
    logic [3:0]       cnt_r, cnt_nx;
    logic [WIDTH-1:0] d_r, d_nx;
    logic             strobe_r, strobe_nx;
    logic             ack0_r, ack0_nx;
    logic             ack1_r, ack1_nx;
    logic             frst_r, frst_nx;
    logic             done_r, done_nx;
    logic             busy_r, busy_nx;
    logic             grant1_s;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_nx  = state_r;
        last_nx   = last_r;
        pend_nx   = pend_r;
        cnt_nx    = cnt_r;
        d_nx      = d_r;
        strobe_nx = 1'b0;
        ack0_nx   = 1'b0;
        ack1_nx   = 1'b0;
        frst_nx   = 1'b0;
        done_nx   = 1'b0;
        grant1_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush || pend_r) begin
                    state_nx = ST_FLUSH;
                    pend_nx  = 1'b0;
                    cnt_nx   = FLUSH_LOAD;
                    frst_nx  = 1'b1;
                end else if (!fifo_full && (req0 || req1)) begin
                    // On a tie the requester not granted last time wins
                    if (req0 && req1) begin
                        grant1_s = ~last_r;
                    end else begin
                        grant1_s = req1;
                    end
                    d_nx      = grant1_s ? d1 : d0;
                    strobe_nx = 1'b1;
                    ack0_nx   = ~grant1_s;
                    ack1_nx   = grant1_s;
                    last_nx   = grant1_s;
                    state_nx  = ST_WRITE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_nx = ST_IDLE;
                if (flush) begin
                    pend_nx = 1'b1;
                end else begin
                    pend_nx = pend_r;
                end
            end
            ST_FLUSH: begin
                if (cnt_r <= 4'd1) begin
                    state_nx = ST_DRAIN;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx  = cnt_r - 4'd1;
                    frst_nx = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    done_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_DRAIN;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        busy_nx = (state_nx != ST_IDLE);
    end

    // Registered outputs and arbitration bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_r   <= 1'b1;
            pend_r   <= 1'b0;
            cnt_r    <= 4'd0;
            d_r      <= '0;
            strobe_r <= 1'b0;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            frst_r   <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            last_r   <= last_nx;
            pend_r   <= pend_nx;
            cnt_r    <= cnt_nx;
            d_r      <= d_nx;
            strobe_r <= strobe_nx;
            ack0_r   <= ack0_nx;
            ack1_r   <= ack1_nx;
            frst_r   <= frst_nx;
            done_r   <= done_nx;
            busy_r   <= busy_nx;
        end
    end

    assign ack0             = ack0_r;
    assign ack1             = ack1_r;
    assign fifo_d_in        = d_r;
    assign fifo_d_in_strobe = strobe_r;
    assign fifo_reset       = frst_r;
    assign flush_done       = done_r;
    assign busy             = busy_r;

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter and sequencer for the write side of the element-chain FIFO. It shares the FIFO's single input (`d_in`/`d_in_strobe`) between two producers. It also sequences FIFO flushes by driving the elements' synchronous `reset` and waiting for the chain to report empty. It sits between the io881 producer ports and the head FIFO element. All outputs are registered.

## Interface
Parameters:
- `WIDTH`, 8, data word width.
- `FLUSH_CYCLES`, 2, number of cycles `fifo_reset` is held high per flush (legal range 1..15).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0`  in  1  producer 0 has a word on `d0` (level).
- `d0`  in  WIDTH  producer 0 data.
- `ack0`  out  1  one-cycle pulse: producer 0 word accepted.
- `req1`  in  1  producer 1 has a word on `d1` (level).
- `d1`  in  WIDTH  producer 1 data.
- `ack1`  out  1  one-cycle pulse: producer 1 word accepted.
- `flush`  in  1  request to clear the FIFO (level or pulse).
- `fifo_full`  in  1  head element `used`; 1 means the FIFO cannot accept a word.
- `fifo_empty`  in  1  1 when no element in the chain is used.
- `fifo_d_in`  out  WIDTH  data to the head element.
- `fifo_d_in_strobe`  out  1  write strobe to the head element.
- `fifo_reset`  out  1  active-high synchronous reset to all elements.
- `flush_done`  out  1  one-cycle pulse when a flush completes.
- `busy`  out  1  high in any state other than IDLE.

## Operation
States are IDLE, WRITE, FLUSH and DRAIN.

- **Reset (`reset_n`=0, asynchronous)**
  - State goes to IDLE; all outputs go to 0, including `fifo_d_in`.
  - `last` (the last-granted requester) is set to 1, so producer 0 wins the first tie.
  - `flush_pend` is cleared.
- **IDLE**, evaluated at each rising edge, in priority order:
  - If `flush` or `flush_pend` is set: go to FLUSH, clear `flush_pend`, load the counter with FLUSH_CYCLES, assert `fifo_reset`.
  - Else if `fifo_full`=0 and any `req` is high: grant one requester.
    - If only one requester is high, it is granted.
    - If both are high, the requester ≠ `last` is granted.
    - The grant registers the selected data onto `fifo_d_in`, sets `fifo_d_in_strobe`=1 and the matching `ack`=1, updates `last`, and moves to WRITE.
  - Else stay in IDLE.
- **WRITE** (one cycle):
  - Clear the strobe and ack and return to IDLE.
  - No grant is made here. This gives the producer one edge to see the ack and drop or update its request, so a word is never double-accepted.
  - A `flush` sampled here sets `flush_pend`.
  - `fifo_d_in` holds its value until the next grant.
- **FLUSH**:
  - `fifo_reset`=1 while the counter is non-zero; the counter decrements each edge.
  - When the counter reaches 1, go to DRAIN and drop `fifo_reset`.
  - `req` inputs are ignored: no ack and no strobe.
- **DRAIN**:
  - Wait for `fifo_empty`=1, then pulse `flush_done` for one cycle and return to IDLE.
  - A `flush` seen here is ignored, since the flush in progress covers it.
- **Boundary conditions**
  - `fifo_full` is sampled only in IDLE.
  - A requester that drops `req` before it is granted loses the request silently.
  - Flush has priority over a simultaneous `req`.
  - A `reset_n` assertion mid-FLUSH drops `fifo_reset` immediately. The elements then rely on their own reset path.

## Timing
- **Grant latency:** a `req` sampled at edge k in IDLE with `fifo_full`=0 produces `fifo_d_in_strobe`, `ack` and `fifo_d_in` valid from edge k to edge k+1.
- **Throughput:** at most one word every 2 cycles.
- **Flush:** flush sampled at edge k gives `fifo_reset` high from edge k through edge k+FLUSH_CYCLES.
  - DRAIN is entered at edge k+FLUSH_CYCLES.
  - `flush_done` goes high one edge after `fifo_empty` is sampled 1 in DRAIN.
- **`busy`:** registered alongside the state, high from the edge leaving IDLE to the edge re-entering it.
- **Pulses:** `ack0`, `ack1` and `flush_done` are each exactly one cycle wide.

## Test plan
- **Async reset:** drive all outputs non-zero, then pull `reset_n` low mid-cycle → all outputs are 0 before the next edge and state is IDLE. After release, `req0`=`req1`=1 → `ack0` is first.
- **Single producer:** `req0`=1, `d0`=8'hAA, `fifo_full`=0 → one edge later `fifo_d_in`=AA, `fifo_d_in_strobe`=1, `ack0`=1 for exactly one cycle. With `req0` held, the next strobe comes 2 edges after the first.
- **Round robin:** `req0` and `req1` held, `d0`=8'h11, `d1`=8'h22 → strobed data sequence is 11, 22, 11, 22 at 2-cycle spacing.
- **Backpressure:** `fifo_full`=1, `req1`=1 for 5 cycles → no strobe and no ack. Drop `fifo_full` → strobe with `d1` on the next edge.
- **Flush:** FLUSH_CYCLES=2, pulse `flush` together with `req0`=1, hold `fifo_empty`=0 for 3 cycles after `fifo_reset` falls.
  - `fifo_reset` is high for exactly 2 cycles, with no ack during the flush.
  - `flush_done` pulses one cycle after `fifo_empty` rises; `req0` is then granted.
- **Flush in WRITE / reset mid-flush:**
  - `flush` pulsed during a WRITE cycle → FLUSH is entered at the next IDLE edge.
  - `reset_n` low during FLUSH → `fifo_reset` is 0 immediately, and after release `busy`=0.
